// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
//               The optional feature macro IFETCH_PERF_EN is consumed by
//               instr_fetch, not by this package.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  // Fetch controller states (explicit 2-bit encoding)
  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_FLUSH = 2'd2
  } if_state_t;

  // Values shown on the decode-facing outputs while the queue is empty
  localparam int IF_RESET_INSTR = 0;
  localparam int IF_RESET_PC    = 0;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundles the pc-side, instruction-memory and decode-side
//               signals of the fetch stage. The fetch stage uses the master
//               modport; its surroundings (pc, memory, decode) use slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0] pc_addr;
  logic              pc_stall;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    input  pc_addr, flush, imem_rdata, instr_ready,
    output pc_stall, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output pc_addr, flush, imem_rdata, instr_ready,
    input  pc_stall, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

endinterface
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_fifo
// Description : Small circular queue of {fetch address, instruction} pairs.
//               Head is read combinationally; clear empties the queue and
//               takes priority over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              push,
  input  wire logic              pop,
  input  wire logic              clear,
  input  wire logic [ADDR_W-1:0] push_addr,
  input  wire logic [DATA_W-1:0] push_data,
  output logic      [ADDR_W-1:0] head_addr,
  output logic      [DATA_W-1:0] head_data,
  output logic      [CW-1:0]     count,
  output logic                   empty
);

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      addr_mem_q[wptr_q] <= push_addr;
      data_mem_q[wptr_q] <= push_data;
    end
  end

  assign head_addr = addr_mem_q[rptr_q];
  assign head_data = data_mem_q[rptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction-fetch stage. Issues one-cycle-latency reads at
//               the pc address, queues {address, instruction} and presents
//               the head to decode over valid/ready. Credit check counts the
//               in-flight read so the queue cannot overflow.
//               Optional: IFETCH_PERF_EN adds a saturating stall_cycles
//               counter of fetch-state stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic     clk,
  input  wire logic     rst,
  instr_fetch_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] C_DEPTH = DEPTH[CW:0];

  if_state_t         state_q, state_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CW:0]       w_occupancy;
  logic              w_req;
  logic              w_push;
  logic              w_pop;

  // Credit check deliberately ignores a same-cycle pop
  assign w_occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign w_req       = (state_q == IF_FETCH) && !bus.flush && (w_occupancy < C_DEPTH);

  // A flush discards the returning response and any pop in the same cycle
  assign w_push = inflight_q && !bus.flush;
  assign w_pop  = !fifo_empty && bus.instr_ready && !bus.flush;

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = bus.pc_addr;
  assign bus.pc_stall    = !w_req;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? DATA_W'(IF_RESET_INSTR) : head_data;
  assign bus.instr_pc    = fifo_empty ? ADDR_W'(IF_RESET_PC)    : head_addr;

  // Next state, in-flight flag and captured request address
  always_comb begin
    state_d    = state_q;
    inflight_d = w_req;
    req_addr_d = w_req ? bus.pc_addr : req_addr_q;
    case (state_q)
      IF_IDLE:  state_d = IF_FETCH;
      IF_FETCH: if (bus.flush)  state_d = IF_FLUSH;
      IF_FLUSH: if (!bus.flush) state_d = IF_FETCH;
      default:  state_d = IF_IDLE;
    endcase
  end

  // Fetch controller registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IF_IDLE;
      inflight_q <= 1'b0;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      req_addr_q <= req_addr_d;
    end
  end

  ifetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .clear     (bus.flush),
    .push_addr (req_addr_q),
    .push_data (bus.imem_rdata),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of cycles spent stalled while fetching
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((state_q == IF_FETCH) && !w_req && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire
